// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared constants for the 5-stage pipeline controller: datapath
//               widths and the sequencing FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  // Sequencing FSM state encoding (kept as plain vectors for legacy tools)
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard comparator between the load in
//               ID/EX and the source operands of the instruction in IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic             i_uses_rs1,
  input  logic             i_uses_rs2,
  input  logic             i_memread,
  input  logic [REG_W-1:0] i_rd,
  output logic             o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard
  always_comb begin
    w_rs1_hit  = i_uses_rs1 && (i_rs1 == i_rd);
    w_rs2_hit  = i_uses_rs2 && (i_rs2 == i_rd);
    o_load_use = i_memread && (i_rd != '0) && (w_rs1_hit || w_rs2_hit);
  end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Hazard and sequencing controller for the 5-stage pipeline.
//               Drives per-stage enables/flushes, PC redirect on branches
//               resolved in MEM, the data-memory req/ready handshake with a
//               timeout, and saturating stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             ifid_uses_rs1,
  input  logic             ifid_uses_rs2,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic [XLEN-1:0]  exmem_adder,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             pc_sel,
  output logic [XLEN-1:0]  pc_target,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [1:0]        r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic [1:0]        w_next_state;
  logic              w_memop;
  logic              w_branch;
  logic              w_load_use;
  logic              w_mem_stall;
  logic              w_lu_stall;
  logic              w_branch_taken;
  logic              w_timeout;

  // Hazard inputs are masked while in reset so outputs settle to RUN values
  always_comb begin
    w_memop  = reset_n && (exmem_memread || exmem_memwrite);
    w_branch = reset_n && exmem_branch && exmem_zero;
  end

  hazard_detect u_hazard_detect (
    .i_rs1      (ifid_rs1),
    .i_rs2      (ifid_rs2),
    .i_uses_rs1 (ifid_uses_rs1),
    .i_uses_rs2 (ifid_uses_rs2),
    .i_memread  (idex_memread && reset_n),
    .i_rd       (idex_rd),
    .o_load_use (w_load_use)
  );

  // Output decode and next-state logic; priority ERROR > mem stall > branch > load-use
  always_comb begin
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    idex_write     = 1'b1;
    exmem_write    = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    memwb_bubble   = 1'b0;
    pc_sel         = 1'b0;
    dmem_req       = 1'b0;
    w_next_state   = r_state;
    w_mem_stall    = 1'b0;
    w_lu_stall     = 1'b0;
    w_branch_taken = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      ST_RUN: begin
        dmem_req = w_memop;
        if (w_memop && !dmem_ready) begin
          {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
          memwb_bubble = 1'b1;
          w_mem_stall  = 1'b1;
          w_next_state = ST_MEM_WAIT;
        end else if (w_branch && !w_memop) begin
          // Flushing IF/ID and ID/EX also removes any load-use victim
          pc_sel         = 1'b1;
          ifid_flush     = 1'b1;
          idex_flush     = 1'b1;
          exmem_flush    = 1'b1;
          w_branch_taken = 1'b1;
        end else if (w_load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          w_lu_stall = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        dmem_req = w_memop;
        if (dmem_ready) begin
          w_next_state = ST_RUN;
          if (w_load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            w_lu_stall = 1'b1;
          end
        end else begin
          {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
          memwb_bubble = 1'b1;
          w_mem_stall  = 1'b1;
          // The count reaching the limit on this cycle ends the wait
          if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            w_timeout    = 1'b1;
            w_next_state = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
        memwb_bubble = 1'b1;
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  // State, wait counter and sticky error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_RUN && w_mem_stall) begin
        r_wait_cnt <= WAIT_W'(1);
      end else if (r_state == ST_MEM_WAIT) begin
        r_wait_cnt <= dmem_ready ? '0 : r_wait_cnt + WAIT_W'(1);
      end
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((w_mem_stall || w_lu_stall) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_branch_taken && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign pc_target = exmem_adder;
  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl
//               (MEM_TIMEOUT=4, CNT_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;
  import pipeline_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [REG_W-1:0] ifid_rs1, ifid_rs2, idex_rd;
  logic             ifid_uses_rs1, ifid_uses_rs2, idex_memread;
  logic             exmem_branch, exmem_zero, exmem_memread, exmem_memwrite;
  logic [XLEN-1:0]  exmem_adder;
  logic             dmem_ready;
  logic             pc_write, ifid_write, idex_write, exmem_write;
  logic             ifid_flush, idex_flush, exmem_flush, memwb_bubble;
  logic             pc_sel, dmem_req, mem_err;
  logic [XLEN-1:0]  pc_target;
  logic [1:0]       stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // {pc_write, ifid_write, idex_write, exmem_write,
  //  ifid_flush, idex_flush, exmem_flush, memwb_bubble, pc_sel, dmem_req}
  logic [9:0] ctl;
  assign ctl = {pc_write, ifid_write, idex_write, exmem_write,
                ifid_flush, idex_flush, exmem_flush, memwb_bubble, pc_sel, dmem_req};

  localparam logic [9:0] C_IDLE   = 10'b1111_000_0_0_0;
  localparam logic [9:0] C_LU     = 10'b0011_010_0_0_0;
  localparam logic [9:0] C_BR     = 10'b1111_111_0_1_0;
  localparam logic [9:0] C_MSTALL = 10'b0000_000_1_0_1;
  localparam logic [9:0] C_MDONE  = 10'b1111_000_0_0_1;
  localparam logic [9:0] C_ERR    = 10'b0000_000_1_0_0;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .exmem_branch(exmem_branch), .exmem_zero(exmem_zero), .exmem_adder(exmem_adder),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_bubble(memwb_bubble),
    .pc_sel(pc_sel), .pc_target(pc_target), .dmem_req(dmem_req),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifid_rs1 = '0; ifid_rs2 = '0; idex_rd = '0;
    ifid_uses_rs1 = 1'b0; ifid_uses_rs2 = 1'b0; idex_memread = 1'b0;
    exmem_branch = 1'b0; exmem_zero = 1'b0; exmem_adder = '0;
    exmem_memread = 1'b0; exmem_memwrite = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    idex_memread = 1'b1; idex_rd = rd; ifid_rs1 = rd; ifid_uses_rs1 = 1'b1;
  endtask

  // Short asynchronous pulse, away from any clock edge
  task automatic apply_reset();
    clear_inputs();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    set_load_use(5'd5);
    exmem_branch = 1'b1; exmem_zero = 1'b1; exmem_adder = 32'h0000_1234;
    exmem_memread = 1'b1; dmem_ready = 1'b0;
    #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_IDLE); end
    checks++; if (pc_target !== 32'h0000_1234) begin errors++; $display("FAIL reset_target got=%h exp=00001234", pc_target); end
    tick();
    checks++; if ({mem_err, stall_cnt, flush_cnt} !== 5'b0) begin errors++; $display("FAIL reset_regs got=%b exp=00000", {mem_err, stall_cnt, flush_cnt}); end
    clear_inputs();
    reset_n = 1'b1;
    tick();
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL idle_ctl got=%b exp=%b", ctl, C_IDLE); end
  endtask

  task automatic test_load_use();
    apply_reset();
    set_load_use(5'd5);
    #1;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs1_ctl got=%b exp=%b", ctl, C_LU); end
    tick();
    checks++; if (stall_cnt !== 2'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    idex_memread = 1'b0;
    #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_bubble_clears got=%b exp=%b", ctl, C_IDLE); end
    set_load_use(5'd0);
    #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_x0 got=%b exp=%b", ctl, C_IDLE); end
    tick();
    checks++; if (stall_cnt !== 2'd1) begin errors++; $display("FAIL lu_x0_cnt got=%0d exp=1", stall_cnt); end
    clear_inputs();
    idex_memread = 1'b1; idex_rd = 5'd7; ifid_rs1 = 5'd3; ifid_rs2 = 5'd7;
    ifid_uses_rs1 = 1'b1; ifid_uses_rs2 = 1'b1;
    #1;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs2_ctl got=%b exp=%b", ctl, C_LU); end
    ifid_uses_rs2 = 1'b0;
    #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_rs2_unused got=%b exp=%b", ctl, C_IDLE); end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch();
    apply_reset();
    exmem_branch = 1'b1; exmem_zero = 1'b1; exmem_adder = 32'h0000_0040;
    #1;
    checks++; if (ctl !== C_BR) begin errors++; $display("FAIL br_ctl got=%b exp=%b", ctl, C_BR); end
    checks++; if (pc_target !== 32'h0000_0040) begin errors++; $display("FAIL br_target got=%h exp=00000040", pc_target); end
    tick();
    checks++; if (flush_cnt !== 2'd1) begin errors++; $display("FAIL br_flush_cnt got=%0d exp=1", flush_cnt); end
    exmem_zero = 1'b0;
    #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL br_not_taken got=%b exp=%b", ctl, C_IDLE); end
    tick();
    checks++; if (flush_cnt !== 2'd1) begin errors++; $display("FAIL br_not_taken_cnt got=%0d exp=1", flush_cnt); end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    apply_reset();
    exmem_memread = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) set_load_use(5'd9);
      #1;
      checks++; if (ctl !== C_MSTALL) begin errors++; $display("FAIL mw_stall_%0d got=%b exp=%b", c, ctl, C_MSTALL); end
      tick();
    end
    idex_memread = 1'b0; ifid_uses_rs1 = 1'b0; dmem_ready = 1'b1;
    #1;
    checks++; if (ctl !== C_MDONE) begin errors++; $display("FAIL mw_done got=%b exp=%b", ctl, C_MDONE); end
    tick();
    checks++; if (stall_cnt !== 2'd3) begin errors++; $display("FAIL mw_stall_cnt got=%0d exp=3", stall_cnt); end
    clear_inputs();
    exmem_branch = 1'b1; exmem_zero = 1'b1; exmem_adder = 32'h0000_0100;
    #1;
    checks++; if (ctl !== C_BR) begin errors++; $display("FAIL mw_back_in_run got=%b exp=%b", ctl, C_BR); end
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout();
    apply_reset();
    exmem_memwrite = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (ctl !== C_MSTALL) begin errors++; $display("FAIL to_wait_%0d got=%b exp=%b", c, ctl, C_MSTALL); end
      checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL to_early_err_%0d got=%b exp=0", c, mem_err); end
      tick();
    end
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_mem_err got=%b exp=1", mem_err); end
    checks++; if (ctl !== C_ERR) begin errors++; $display("FAIL to_err_ctl got=%b exp=%b", ctl, C_ERR); end
    dmem_ready = 1'b1;
    exmem_branch = 1'b1; exmem_zero = 1'b1;
    tick();
    checks++; if ({ctl, mem_err} !== {C_ERR, 1'b1}) begin errors++; $display("FAIL to_frozen got=%b exp=%b", {ctl, mem_err}, {C_ERR, 1'b1}); end
    checks++; if (stall_cnt !== 2'd3) begin errors++; $display("FAIL to_stall_cnt got=%0d exp=3", stall_cnt); end
    apply_reset();
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL to_reset_err got=%b exp=0", mem_err); end
    exmem_memwrite = 1'b1; dmem_ready = 1'b1;
    #1;
    checks++; if (ctl !== C_MDONE) begin errors++; $display("FAIL to_reset_run got=%b exp=%b", ctl, C_MDONE); end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch_load_use();
    apply_reset();
    set_load_use(5'd12);
    exmem_branch = 1'b1; exmem_zero = 1'b1; exmem_adder = 32'h0000_0080;
    #1;
    checks++; if (ctl !== C_BR) begin errors++; $display("FAIL bl_ctl got=%b exp=%b", ctl, C_BR); end
    tick();
    checks++; if ({stall_cnt, flush_cnt} !== 4'b00_01) begin errors++; $display("FAIL bl_counts got=%b exp=0001", {stall_cnt, flush_cnt}); end
    clear_inputs();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    apply_reset();
    set_load_use(5'd4);
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (stall_cnt !== exp_cnt[c]) begin errors++; $display("FAIL sat_stall_%0d got=%0d exp=%0d", c, stall_cnt, exp_cnt[c]); end
    end
    clear_inputs();
    exmem_branch = 1'b1; exmem_zero = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    checks++; if (flush_cnt !== 2'd3) begin errors++; $display("FAIL sat_flush got=%0d exp=3", flush_cnt); end
    clear_inputs();
  endtask

  task automatic test_async_reset_mid_wait();
    apply_reset();
    exmem_branch = 1'b1; exmem_zero = 1'b1;
    tick();
    clear_inputs();
    exmem_memread = 1'b1; dmem_ready = 1'b0;
    tick();
    tick();
    checks++; if ({stall_cnt, flush_cnt} !== 4'b10_01) begin errors++; $display("FAIL ar_pre got=%b exp=1001", {stall_cnt, flush_cnt}); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({mem_err, stall_cnt, flush_cnt} !== 5'b0) begin errors++; $display("FAIL ar_cleared got=%b exp=00000", {mem_err, stall_cnt, flush_cnt}); end
    reset_n = 1'b1;
    exmem_memread = 1'b0;
    #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL ar_run got=%b exp=%b", ctl, C_IDLE); end
    tick();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    tick();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_branch_load_use();
    test_saturation();
    test_async_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipeline_ctrl
`default_nettype wire
